// File: rtl/output_collector_pkg.sv
// Shared types and helpers for the output collector: FSM states, lane count
// and the signed saturation helper used by every lane.
package output_collector_pkg;

  localparam int N_COL     = 4;
  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Caller sign-extends an ACC_W value to SAT_MAX_W; result keeps OUT_W significant bits.
  function automatic logic signed [SAT_MAX_W-1:0] sat_to_out(
    input logic signed [SAT_MAX_W-1:0] val,
    input int unsigned                 out_w
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (val > hi) begin
      sat_to_out = hi;
    end else if (val < lo) begin
      sat_to_out = lo;
    end else begin
      sat_to_out = val;
    end
  endfunction

endpackage

// File: rtl/output_collector_if.sv
// Control/array/memory bundle seen by the output collector.
interface output_collector_if #(
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 4
);
  import output_collector_pkg::*;

  logic                    LOAD_EN;
  logic [ADDR_W-1:0]       ODST;
  logic                    START_CALC;
  logic [N_COL-1:0]        col_valid;
  logic [N_COL*ACC_W-1:0]  col_data;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [N_COL*OUT_W-1:0]  mem_wdata;
  logic                    mem_ready;
  logic                    row_done;
  logic                    sat_flag;
  logic                    collect_err;
  logic                    clr_err;

  modport slave (
    input  LOAD_EN, ODST, START_CALC, col_valid, col_data, mem_ready, clr_err,
    output mem_we, mem_addr, mem_wdata, row_done, sat_flag, collect_err
  );

  modport master (
    output LOAD_EN, ODST, START_CALC, col_valid, col_data, mem_ready, clr_err,
    input  mem_we, mem_addr, mem_wdata, row_done, sat_flag, collect_err
  );
endinterface

// File: rtl/output_collector_sat_lane.sv
// One column lane: clamps a signed accumulator result to the stored width and
// flags whether the clamp changed the value.
module sat_lane
  import output_collector_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [OUT_W-1:0] lane,
  output logic                    clamp
);

  logic signed [SAT_MAX_W-1:0] wide_s;
  logic signed [SAT_MAX_W-1:0] sat_s;

  always_comb begin
    wide_s = {{(SAT_MAX_W-ACC_W){acc[ACC_W-1]}}, acc};
    sat_s  = sat_to_out(wide_s, OUT_W);
    lane   = sat_s[OUT_W-1:0];
    clamp  = (sat_s != wide_s);
  end

endmodule

// File: rtl/output_collector.sv
// Collects the four skewed column results of one output row, saturates them,
// writes the packed row to output memory and pulses row_done to control.
module output_collector
  import output_collector_pkg::*;
#(
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               CLK,
  input  logic               RSTN,
  output_collector_if.slave  bus
);

  state_e            state_q, state_d;
  logic [N_COL-1:0]  mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OUT_W-1:0]  lane_q [N_COL];
  logic [OUT_W-1:0]  lane_d [N_COL];
  logic              sat_q, sat_d;
  logic              err_q, err_d;

  logic [OUT_W-1:0]  lane_sat_s [N_COL];
  logic [N_COL-1:0]  clamp_s;
  logic [N_COL-1:0]  capture_s;
  logic              err_event_s;
  logic              sat_event_s;

  for (genvar j = 0; j < N_COL; j++) begin : g_lane
    sat_lane #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat (
      .acc   (bus.col_data[j*ACC_W +: ACC_W]),
      .lane  (lane_sat_s[j]),
      .clamp (clamp_s[j])
    );
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Completion looks at the mask including this cycle's captures.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.START_CALC) state_d = ST_COLLECT; else state_d = ST_IDLE;
      ST_COLLECT: if ((mask_q | capture_s) == {N_COL{1'b1}}) state_d = ST_WRITE;
                  else state_d = ST_COLLECT;
      ST_WRITE:   if (bus.mem_ready) state_d = ST_DONE; else state_d = ST_WRITE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    capture_s = (state_q == ST_COLLECT) ? (bus.col_valid & ~mask_q) : {N_COL{1'b0}};
    if ((state_q == ST_IDLE) && bus.START_CALC) begin
      mask_d = {N_COL{1'b0}};
    end else begin
      mask_d = mask_q | capture_s;
    end
    for (int j = 0; j < N_COL; j++) begin
      lane_d[j] = capture_s[j] ? lane_sat_s[j] : lane_q[j];
    end
    addr_d = bus.LOAD_EN ? bus.ODST : addr_q;

    err_event_s = ((state_q != ST_COLLECT) && (|bus.col_valid))
               || ((state_q != ST_IDLE) && bus.START_CALC)
               || ((state_q == ST_COLLECT) && (|(bus.col_valid & mask_q)));
    sat_event_s = |(capture_s & clamp_s);

    // A set event beats a clear in the same cycle.
    if (sat_event_s) begin
      sat_d = 1'b1;
    end else if (bus.clr_err) begin
      sat_d = 1'b0;
    end else begin
      sat_d = sat_q;
    end
    if (err_event_s) begin
      err_d = 1'b1;
    end else if (bus.clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mask_q <= {N_COL{1'b0}};
      addr_q <= {ADDR_W{1'b0}};
      sat_q  <= 1'b0;
      err_q  <= 1'b0;
      for (int j = 0; j < N_COL; j++) begin
        lane_q[j] <= {OUT_W{1'b0}};
      end
    end else begin
      mask_q <= mask_d;
      addr_q <= addr_d;
      sat_q  <= sat_d;
      err_q  <= err_d;
      for (int j = 0; j < N_COL; j++) begin
        lane_q[j] <= lane_d[j];
      end
    end
  end

  always_comb begin
    bus.mem_we      = (state_q == ST_WRITE);
    bus.row_done    = (state_q == ST_DONE);
    bus.mem_addr    = addr_q;
    bus.sat_flag    = sat_q;
    bus.collect_err = err_q;
    bus.mem_wdata   = {(N_COL*OUT_W){1'b0}};
    for (int j = 0; j < N_COL; j++) begin
      bus.mem_wdata[j*OUT_W +: OUT_W] = lane_q[j];
    end
  end

endmodule

// File: tb/tb_output_collector.sv
// Self-checking bench for output_collector: directed rows plus random rows
// checked against a first-arrival-wins row model with integer saturation.
module tb_output_collector;

  localparam int ACC_W  = 20;
  localparam int OUT_W  = 16;
  localparam int ADDR_W = 4;
  localparam int MAXV   = 32767;
  localparam int MINV   = -32768;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  output_collector_if #(.ACC_W(ACC_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

  output_collector #(.ACC_W(ACC_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  int         total = 0;
  int         bad   = 0;
  logic [3:0] got;
  int         val [4];
  logic       exp_sat;
  logic       exp_err;
  logic [3:0] exp_addr;

  function automatic logic [15:0] sat_ref(input int v);
    if (v > MAXV) return 16'h7fff;
    else if (v < MINV) return 16'h8000;
    else return v[15:0];
  endfunction

  function automatic logic sat_hit(input int v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic [63:0] exp_row();
    logic [63:0] r;
    for (int j = 0; j < 4; j++) r[j*16 +: 16] = sat_ref(val[j]);
    return r;
  endfunction

  function automatic int rnd_data();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 1048575)) - 524288;
    else return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_row(input logic [3:0] a);
    bus.LOAD_EN    = 1'b1;
    bus.ODST       = a;
    bus.START_CALC = 1'b1;
    got            = 4'b0000;
    exp_addr       = a;
    tick();
    bus.LOAD_EN    = 1'b0;
    bus.START_CALC = 1'b0;
    chk("start_we", {63'd0, bus.mem_we}, 64'd0);
    chk("start_addr", {60'd0, bus.mem_addr}, {60'd0, exp_addr});
  endtask

  task automatic collect(input logic [3:0] v, input int d0, input int d1,
                         input int d2, input int d3, input logic sc);
    int d [4];
    logic [19:0] raw;
    d = '{d0, d1, d2, d3};
    for (int j = 0; j < 4; j++) begin
      raw = d[j][19:0];
      bus.col_data[j*20 +: 20] = raw;
      if (v[j]) begin
        if (got[j]) begin
          exp_err = 1'b1;
        end else begin
          got[j] = 1'b1;
          val[j] = d[j];
          if (sat_hit(d[j])) exp_sat = 1'b1;
        end
      end
    end
    if (sc) exp_err = 1'b1;
    bus.col_valid  = v;
    bus.START_CALC = sc;
    tick();
    bus.col_valid  = 4'b0000;
    bus.START_CALC = 1'b0;
    chk("collect_we", {63'd0, bus.mem_we}, {63'd0, (got == 4'hF)});
  endtask

  task automatic finish_row(input int stalls);
    logic [63:0] w;
    w = exp_row();
    for (int s = 0; s <= stalls; s++) begin
      chk("write_we", {63'd0, bus.mem_we}, 64'd1);
      chk("write_addr", {60'd0, bus.mem_addr}, {60'd0, exp_addr});
      chk("write_data", bus.mem_wdata, w);
      chk("write_done_low", {63'd0, bus.row_done}, 64'd0);
      bus.mem_ready = (s == stalls);
      tick();
    end
    bus.mem_ready = 1'b0;
    chk("done_pulse", {63'd0, bus.row_done}, 64'd1);
    chk("done_we", {63'd0, bus.mem_we}, 64'd0);
    tick();
    chk("done_single", {63'd0, bus.row_done}, 64'd0);
    chk("sat_flag", {63'd0, bus.sat_flag}, {63'd0, exp_sat});
    chk("collect_err", {63'd0, bus.collect_err}, {63'd0, exp_err});
  endtask

  task automatic clear_flags();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    exp_sat = 1'b0;
    exp_err = 1'b0;
    chk("clr_sat", {63'd0, bus.sat_flag}, 64'd0);
    chk("clr_err", {63'd0, bus.collect_err}, 64'd0);
  endtask

  initial begin
    bus.LOAD_EN = 1'b0; bus.ODST = 4'd0; bus.START_CALC = 1'b0;
    bus.col_valid = 4'b0000; bus.col_data = 80'd0; bus.mem_ready = 1'b0;
    bus.clr_err = 1'b0;
    got = 4'b0000; exp_sat = 1'b0; exp_err = 1'b0; exp_addr = 4'd0;
    for (int j = 0; j < 4; j++) val[j] = 0;

    // Reset state
    repeat (3) tick();
    chk("rst_we", {63'd0, bus.mem_we}, 64'd0);
    chk("rst_addr", {60'd0, bus.mem_addr}, 64'd0);
    chk("rst_wdata", bus.mem_wdata, 64'd0);
    chk("rst_done", {63'd0, bus.row_done}, 64'd0);
    chk("rst_sat", {63'd0, bus.sat_flag}, 64'd0);
    chk("rst_err", {63'd0, bus.collect_err}, 64'd0);
    RSTN = 1'b1;
    repeat (10) begin
      tick();
      chk("idle_we", {63'd0, bus.mem_we}, 64'd0);
    end

    // Skewed row
    start_row(4'd2);
    collect(4'b0001, 5, 0, 0, 0, 1'b0);
    collect(4'b0010, 0, -7, 0, 0, 1'b0);
    collect(4'b0100, 0, 0, 100, 0, 1'b0);
    collect(4'b1000, 0, 0, 0, 0, 1'b0);
    chk("skew_wdata", bus.mem_wdata, 64'h0000_0064_fff9_0005);
    finish_row(0);

    // Saturation with all columns at once
    start_row(4'd5);
    collect(4'b1111, 40000, -40000, 32767, -32768, 1'b0);
    chk("sat_wdata", bus.mem_wdata, 64'h8000_7fff_8000_7fff);
    finish_row(0);
    chk("sat_set", {63'd0, bus.sat_flag}, 64'd1);
    clear_flags();

    // Memory stall
    start_row(4'd9);
    collect(4'b0011, 1234, -4321, 0, 0, 1'b0);
    collect(4'b1100, 0, 0, 77, -1, 1'b0);
    finish_row(3);

    // Duplicate column
    start_row(4'd1);
    collect(4'b0010, 0, 9, 0, 0, 1'b0);
    collect(4'b0011, 3, 11, 0, 0, 1'b0);
    collect(4'b1100, 0, 0, -4, 6, 1'b0);
    chk("dup_lane1", {48'd0, bus.mem_wdata[31:16]}, 64'd9);
    finish_row(0);
    clear_flags();

    // Stray column strobe while idle
    bus.col_valid = 4'b0001;
    tick();
    bus.col_valid = 4'b0000;
    exp_err = 1'b1;
    chk("stray_err", {63'd0, bus.collect_err}, 64'd1);
    repeat (3) begin
      tick();
      chk("stray_we", {63'd0, bus.mem_we}, 64'd0);
    end
    clear_flags();

    // Reset asserted during WRITE
    start_row(4'd7);
    collect(4'b1111, 1, 2, 3, 4, 1'b0);
    #2 RSTN = 1'b0;
    #1;
    chk("rstw_we", {63'd0, bus.mem_we}, 64'd0);
    chk("rstw_done", {63'd0, bus.row_done}, 64'd0);
    chk("rstw_wdata", bus.mem_wdata, 64'd0);
    chk("rstw_addr", {60'd0, bus.mem_addr}, 64'd0);
    tick();
    RSTN = 1'b1;
    exp_sat = 1'b0; exp_err = 1'b0;
    tick();
    start_row(4'd3);
    collect(4'b1111, -100, 200, -300, 400, 1'b0);
    finish_row(1);

    // Random rows
    for (int r = 0; r < 20; r++) begin
      start_row(4'($urandom_range(0, 15)));
      for (int c = 0; c < 12 && got != 4'hF; c++) begin
        logic [3:0] v;
        v = (c == 11) ? 4'hF : 4'($urandom_range(0, 15));
        collect(v, rnd_data(), rnd_data(), rnd_data(), rnd_data(),
                ($urandom_range(0, 7) == 0));
      end
      finish_row(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) clear_flags();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
